// File: rtl/btb_pkg.sv
// Shared types and the tag-folding helper for the set-associative branch target buffer.
package btb_pkg;

  localparam int PC_W = 32;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    COND     = 3'd1,
    JUMP     = 3'd2,
    CALL     = 3'd3,
    RET      = 3'd4,
    INDIRECT = 3'd5
  } ins_type_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } btb_state_t;

  // XOR of taglen-bit chunks of pc[31:idxw+2], LSB chunk first; the top chunk is zero-padded.
  function automatic logic [PC_W-1:0] fold_tag(input logic [PC_W-1:0] pc,
                                              input int idxw,
                                              input int taglen);
    logic [PC_W-1:0] tag;
    tag = '0;
    for (int b = 0; b < PC_W; b++) begin
      if (b >= idxw + 2) begin
        tag[5'((b - idxw - 2) % taglen)] = tag[5'((b - idxw - 2) % taglen)] ^ pc[5'(b)];
      end
    end
    return tag;
  endfunction

endpackage

// File: rtl/btb_nway_if.sv
// Fetch-lookup, branch-resolution update and flush signals of the BTB, bundled for one connection.
interface btb_nway_if #(
  parameter int NPORT = 2
);
  logic [NPORT-1:0]    lookup_valid;
  logic [NPORT*32-1:0] lookup_pc;
  logic                lookup_stall;
  logic [NPORT-1:0]    resp_hit;
  logic [NPORT*32-1:0] resp_target;
  logic [NPORT*3-1:0]  resp_type;
  logic                upd_valid;
  logic                upd_kill;
  logic [31:0]         upd_pc;
  logic [31:0]         upd_target;
  logic [2:0]          upd_type;
  logic                flush_req;
  logic                ready;

  modport master (
    output lookup_valid, lookup_pc, lookup_stall,
    output upd_valid, upd_kill, upd_pc, upd_target, upd_type, flush_req,
    input  resp_hit, resp_target, resp_type, ready
  );

  modport slave (
    input  lookup_valid, lookup_pc, lookup_stall,
    input  upd_valid, upd_kill, upd_pc, upd_target, upd_type, flush_req,
    output resp_hit, resp_target, resp_type, ready
  );
endinterface

// File: rtl/btb_victim_sel.sv
// Victim way choice for one set: lowest invalid way, otherwise the round-robin pointer.
module btb_victim_sel #(
  parameter int NWAYS = 2,
  parameter int WAYW  = 1
) (
  input  logic [NWAYS-1:0] valid,
  input  logic [WAYW-1:0]  rr,
  output logic [WAYW-1:0]  victim,
  output logic             rr_advance
);

  always_comb begin
    victim     = rr;
    rr_advance = &valid;
    // Descending scan so the lowest invalid way is the last one to win.
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!valid[WAYW'(w)]) begin
        victim = WAYW'(w);
      end
    end
  end

endmodule

// File: rtl/btb_nway.sv
// N-way set-associative BTB: registered multi-lane lookup, update/kill with bypass, flush sweep.
module btb_nway
  import btb_pkg::*;
#(
  parameter int NSETS  = 16,
  parameter int NWAYS  = 2,
  parameter int TAGLEN = 6,
  parameter int NPORT  = 2
) (
  input logic       clk,
  input logic       resetn,
  btb_nway_if.slave bus
);

  localparam int IDXW = $clog2(NSETS);
  localparam int WAYW = (NWAYS > 1) ? $clog2(NWAYS) : 1;

  logic [NWAYS-1:0]  valid_reg  [NSETS];
  logic [WAYW-1:0]   rr_reg     [NSETS];
  logic [TAGLEN-1:0] tag_mem    [NSETS][NWAYS];
  logic [31:0]       target_mem [NSETS][NWAYS];
  logic [2:0]        type_mem   [NSETS][NWAYS];

  btb_state_t        state_reg, state_next;
  logic [IDXW-1:0]   cnt_reg, cnt_next;
  logic              ready;

  logic [NPORT-1:0]    resp_hit_reg;
  logic [NPORT*32-1:0] resp_target_reg;
  logic [NPORT*3-1:0]  resp_type_reg;

  logic [NPORT-1:0]    lane_hit;
  logic [NPORT*32-1:0] lane_target;
  logic [NPORT*3-1:0]  lane_type;

  logic [IDXW-1:0]   upd_idx;
  logic [TAGLEN-1:0] upd_tag;
  logic [NWAYS-1:0]  upd_hit_vec;
  logic              upd_hit;
  logic [WAYW-1:0]   upd_hit_way;
  logic [WAYW-1:0]   victim_way;
  logic              rr_advance;
  logic [WAYW-1:0]   upd_way;
  logic [WAYW-1:0]   rr_inc;
  logic              upd_apply;
  logic              upd_write;
  logic              upd_clear;
  logic              rr_bump;

  assign ready = (state_reg == IDLE);

  assign upd_idx = bus.upd_pc[IDXW+1:2];
  assign upd_tag = TAGLEN'(fold_tag(bus.upd_pc, IDXW, TAGLEN));

  for (genvar gi = 0; gi < NWAYS; gi++) begin : g_upd_hit
    assign upd_hit_vec[gi] = valid_reg[upd_idx][gi] && (tag_mem[upd_idx][gi] == upd_tag);
  end

  assign upd_hit = |upd_hit_vec;

  always_comb begin
    upd_hit_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (upd_hit_vec[WAYW'(w)]) begin
        upd_hit_way = WAYW'(w);
      end
    end
  end

  btb_victim_sel #(
    .NWAYS (NWAYS),
    .WAYW  (WAYW)
  ) u_victim (
    .valid      (valid_reg[upd_idx]),
    .rr         (rr_reg[upd_idx]),
    .victim     (victim_way),
    .rr_advance (rr_advance)
  );

  // A flush request in the same idle cycle takes priority and drops the update.
  assign upd_apply = bus.upd_valid && ready && !bus.flush_req;
  assign upd_write = upd_apply && !bus.upd_kill;
  assign upd_clear = upd_apply && bus.upd_kill && upd_hit;
  assign upd_way   = upd_hit ? upd_hit_way : victim_way;
  assign rr_bump   = upd_write && !upd_hit && rr_advance;
  assign rr_inc    = (NWAYS == 1) ? '0 : rr_reg[upd_idx] + 1'b1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.flush_req) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == IDXW'(NSETS - 1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      valid_reg <= '{default: '0};
      rr_reg    <= '{default: '0};
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == FLUSH) begin
        valid_reg[cnt_reg] <= '0;
      end else if (upd_write) begin
        valid_reg[upd_idx][upd_way] <= 1'b1;
      end else if (upd_clear) begin
        valid_reg[upd_idx][upd_way] <= 1'b0;
      end
      if (rr_bump) begin
        rr_reg[upd_idx] <= rr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && upd_write) begin
      tag_mem[upd_idx][upd_way]    <= upd_tag;
      target_mem[upd_idx][upd_way] <= bus.upd_target;
      type_mem[upd_idx][upd_way]   <= bus.upd_type;
    end
  end

  // Each lane reads the array as it will look after this cycle's update (bypass).
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_lane
    logic [31:0]       pc;
    logic [IDXW-1:0]   idx;
    logic [TAGLEN-1:0] tag;
    logic              slot;
    logic              match;
    logic [31:0]       tgt;
    logic [2:0]        typ;

    assign pc  = bus.lookup_pc[32*gi +: 32];
    assign idx = pc[IDXW+1:2];
    assign tag = TAGLEN'(fold_tag(pc, IDXW, TAGLEN));

    always_comb begin
      slot  = 1'b0;
      match = 1'b0;
      tgt   = '0;
      typ   = NONE;
      for (int w = 0; w < NWAYS; w++) begin
        slot = (upd_write || upd_clear) && (upd_idx == idx) && (upd_way == WAYW'(w));
        if (slot && upd_write) begin
          if (upd_tag == tag) begin
            match = 1'b1;
            tgt   = bus.upd_target;
            typ   = bus.upd_type;
          end
        end else if (!slot && valid_reg[idx][WAYW'(w)] && (tag_mem[idx][WAYW'(w)] == tag)) begin
          match = 1'b1;
          tgt   = target_mem[idx][WAYW'(w)];
          typ   = type_mem[idx][WAYW'(w)];
        end
      end
      if (!(bus.lookup_valid[gi] && ready)) begin
        match = 1'b0;
        tgt   = '0;
        typ   = NONE;
      end
    end

    assign lane_hit[gi]            = match;
    assign lane_target[32*gi +: 32] = tgt;
    assign lane_type[3*gi +: 3]     = typ;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_hit_reg    <= '0;
      resp_target_reg <= '0;
      resp_type_reg   <= '0;
    end else if (!bus.lookup_stall) begin
      resp_hit_reg    <= lane_hit;
      resp_target_reg <= lane_target;
      resp_type_reg   <= lane_type;
    end
  end

  assign bus.resp_hit    = resp_hit_reg;
  assign bus.resp_target = resp_target_reg;
  assign bus.resp_type   = resp_type_reg;
  assign bus.ready       = ready;

endmodule

// File: tb/tb_btb_nway.sv
// Randomized and directed bench for btb_nway, checked every cycle against a set/way table model.
module tb_btb_nway;
  import btb_pkg::*;

  localparam int NSETS  = 16;
  localparam int NWAYS  = 2;
  localparam int TAGLEN = 6;
  localparam int NPORT  = 2;
  localparam int IDXW   = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  btb_nway_if #(.NPORT(NPORT)) bus ();

  btb_nway #(
    .NSETS  (NSETS),
    .NWAYS  (NWAYS),
    .TAGLEN (TAGLEN),
    .NPORT  (NPORT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference table
  bit          m_valid [NSETS][NWAYS];
  logic [5:0]  m_tag   [NSETS][NWAYS];
  logic [31:0] m_tgt   [NSETS][NWAYS];
  logic [2:0]  m_typ   [NSETS][NWAYS];
  int          m_rr    [NSETS];
  int          flush_left = 0;
  logic [NPORT-1:0] exp_hit = '0;
  logic [31:0] exp_tgt [NPORT];
  logic [2:0]  exp_typ [NPORT];
  logic        exp_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [5:0] m_fold(input logic [31:0] pc);
    logic [31:0] x;
    logic [5:0]  t;
    x = pc >> (IDXW + 2);
    t = '0;
    while (x != 0) begin
      t = t ^ x[5:0];
      x = x >> TAGLEN;
    end
    return t;
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic [2:0] ty, input logic kill);
    int s, found, way;
    logic [5:0] tg;
    s = int'((pc >> 2) % NSETS);
    tg = m_fold(pc);
    found = -1;
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) found = w;
    if (found >= 0) begin
      if (kill) m_valid[s][found] = 0;
      else begin
        m_tgt[s][found] = tgt;
        m_typ[s][found] = ty;
      end
    end else if (!kill) begin
      way = -1;
      for (int w = 0; w < NWAYS; w++)
        if (!m_valid[s][w] && way < 0) way = w;
      if (way < 0) begin
        way = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % NWAYS;
      end
      m_valid[s][way] = 1;
      m_tag[s][way]   = tg;
      m_tgt[s][way]   = tgt;
      m_typ[s][way]   = ty;
    end
  endtask

  task automatic model_lookup(input logic [31:0] pc, output logic h,
                              output logic [31:0] t, output logic [2:0] y);
    int s;
    s = int'((pc >> 2) % NSETS);
    h = 0; t = '0; y = '0;
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == m_fold(pc)) begin
        h = 1; t = m_tgt[s][w]; y = m_typ[s][w];
      end
  endtask

  task automatic model_step();
    logic rdy, h;
    logic [31:0] t;
    logic [2:0] y;
    if (!resetn) begin
      foreach (m_valid[s, w]) m_valid[s][w] = 0;
      foreach (m_rr[s]) m_rr[s] = 0;
      flush_left = 0;
      exp_hit = '0;
      for (int p = 0; p < NPORT; p++) begin exp_tgt[p] = '0; exp_typ[p] = '0; end
    end else begin
      rdy = (flush_left == 0);
      if (rdy && bus.upd_valid && !bus.flush_req)
        model_update(bus.upd_pc, bus.upd_target, bus.upd_type, bus.upd_kill);
      if (!bus.lookup_stall) begin
        for (int p = 0; p < NPORT; p++) begin
          model_lookup(bus.lookup_pc[32*p +: 32], h, t, y);
          if (!(bus.lookup_valid[p] && rdy)) begin h = 0; t = '0; y = '0; end
          exp_hit[p] = h; exp_tgt[p] = t; exp_typ[p] = y;
        end
      end
      // Mid-sweep state is invisible (misses, dropped updates), so clear everything at once.
      if (rdy && bus.flush_req) begin
        flush_left = NSETS;
        foreach (m_valid[s, w]) m_valid[s][w] = 0;
      end else if (flush_left > 0) begin
        flush_left--;
      end
    end
    exp_ready = (flush_left == 0);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("ready", 32'(bus.ready), 32'(exp_ready));
    for (int p = 0; p < NPORT; p++) begin
      chk($sformatf("lane%0d_hit", p), 32'(bus.resp_hit[p]), 32'(exp_hit[p]));
      chk($sformatf("lane%0d_target", p), bus.resp_target[32*p +: 32], exp_tgt[p]);
      chk($sformatf("lane%0d_type", p), 32'(bus.resp_type[3*p +: 3]), 32'(exp_typ[p]));
    end
  end

  task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [2:0] ty, input logic kill);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_target = tgt;
    bus.upd_type = ty; bus.upd_kill = kill;
  endtask

  task automatic drive_look(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    bus.lookup_valid = v;
    bus.lookup_pc = {p1, p0};
  endtask

  task automatic tick();
    @(negedge clk);
    bus.upd_valid = 1'b0; bus.upd_kill = 1'b0;
    bus.lookup_valid = '0; bus.flush_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return (32'($urandom_range(0, 3)) << 24) | (32'($urandom_range(0, 1)) << 12) |
           (32'($urandom_range(0, 2)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  localparam logic [31:0] PA  = 32'h1C00_0040;
  localparam logic [31:0] PB  = 32'h2C00_0040;
  localparam logic [31:0] PC_ = 32'h3C00_0040;
  localparam logic [31:0] PD  = 32'h4C00_0040;
  localparam logic [31:0] P80 = 32'h1C00_0080;
  localparam logic [31:0] PE  = 32'h0000_1004;
  localparam logic [31:0] PF  = 32'h0000_2008;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    resetn = 1'b0;
    bus.lookup_valid = '0; bus.lookup_pc = '0; bus.lookup_stall = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_kill = 1'b0; bus.upd_pc = '0;
    bus.upd_target = '0; bus.upd_type = '0; bus.flush_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_hit", 32'(bus.resp_hit), 32'd0);
    resetn = 1'b1;

    drive_upd(PA, 32'h1C00_0100, COND, 1'b0); tick();
    drive_look(2'b01, PA, 32'h0); tick();
    chk("first_hit", 32'(bus.resp_hit), 32'd1);
    chk("first_target", bus.resp_target[31:0], 32'h1C00_0100);
    chk("first_type", 32'(bus.resp_type[2:0]), 32'd1);

    drive_upd(PB, 32'hB0, JUMP, 1'b0); tick();
    drive_upd(PC_, 32'hC0, CALL, 1'b0); tick();
    drive_look(2'b11, PA, PB); tick();
    chk("evict_a_hit", 32'(bus.resp_hit), 32'd2);
    chk("keep_b_target", bus.resp_target[63:32], 32'hB0);
    drive_look(2'b01, PC_, 32'h0); tick();
    chk("c_hit", 32'(bus.resp_hit), 32'd1);
    chk("c_type", 32'(bus.resp_type[2:0]), 32'd3);
    drive_upd(PD, 32'hD0, RET, 1'b0); tick();
    drive_look(2'b11, PB, PD); tick();
    chk("evict_b_hit", 32'(bus.resp_hit), 32'd2);
    chk("d_target", bus.resp_target[63:32], 32'hD0);

    drive_upd(P80, 32'h1C00_0800, INDIRECT, 1'b0); drive_look(2'b11, P80, P80); tick();
    chk("bypass_write_hit", 32'(bus.resp_hit), 32'd3);
    chk("bypass_write_tgt0", bus.resp_target[31:0], 32'h1C00_0800);
    chk("bypass_write_tgt1", bus.resp_target[63:32], 32'h1C00_0800);
    drive_upd(P80, 32'h0, NONE, 1'b1); drive_look(2'b11, P80, P80); tick();
    chk("bypass_kill_hit", 32'(bus.resp_hit), 32'd0);
    chk("bypass_kill_tgt", bus.resp_target[31:0], 32'd0);

    drive_look(2'b11, PD, PD); tick();
    chk("pre_stall_hit", 32'(bus.resp_hit), 32'd3);
    bus.lookup_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_look(2'b11, 32'h1234_5670 + 32'(k * 4), P80); tick();
      chk("stall_hit", 32'(bus.resp_hit), 32'd3);
      chk("stall_target", bus.resp_target[31:0], 32'hD0);
    end
    bus.lookup_stall = 1'b0;
    drive_look(2'b11, P80, 32'h4); tick();
    chk("post_stall_hit", 32'(bus.resp_hit), 32'd0);

    drive_upd(PE, 32'hE0, COND, 1'b0); tick();
    bus.flush_req = 1'b1; tick();
    cnt = 0;
    while (bus.ready == 1'b0 && cnt < 40) begin
      cnt++;
      if (cnt == 5) drive_upd(PF, 32'hF0, JUMP, 1'b0);
      tick();
    end
    chk("flush_len", 32'(cnt), 32'd16);
    drive_look(2'b11, PD, PE); tick();
    chk("flushed_de", 32'(bus.resp_hit), 32'd0);
    drive_look(2'b11, PF, PA); tick();
    chk("flushed_fa", 32'(bus.resp_hit), 32'd0);

    drive_upd(PD, 32'hD1, RET, 1'b0); tick();
    drive_look(2'b11, PD, PD); bus.flush_req = 1'b1; tick();
    chk("pre_flush_hit", 32'(bus.resp_hit), 32'd3);
    chk("pre_flush_tgt", bus.resp_target[31:0], 32'hD1);
    bus.lookup_stall = 1'b1;
    repeat (5) tick();
    chk("mid_flush_ready", 32'(bus.ready), 32'd0);
    chk("mid_flush_hold", 32'(bus.resp_hit), 32'd3);
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("rst_flush_ready", 32'(bus.ready), 32'd1);
    chk("rst_flush_hit", 32'(bus.resp_hit), 32'd0);
    chk("rst_flush_tgt", bus.resp_target[31:0], 32'd0);
    chk("rst_flush_type", 32'(bus.resp_type), 32'd0);
    bus.lookup_stall = 1'b0;
    drive_look(2'b11, PD, PA); tick();
    chk("rst_flush_miss", 32'(bus.resp_hit), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 499) != 0);
      bus.upd_valid = ($urandom_range(0, 2) == 0);
      bus.upd_kill = ($urandom_range(0, 3) == 0);
      bus.upd_pc = rand_pc();
      bus.upd_target = $urandom;
      bus.upd_type = 3'($urandom_range(0, 5));
      bus.lookup_valid = 2'($urandom_range(0, 3));
      bus.lookup_pc = {rand_pc(), rand_pc()};
      if ($urandom_range(0, 3) == 0) bus.lookup_pc[31:0] = bus.upd_pc;
      bus.lookup_stall = ($urandom_range(0, 9) == 0);
      bus.flush_req = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    resetn = 1'b1;
    bus.lookup_stall = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
